// File: rtl/alu_mdu_iter.sv
// ============================================================================
// alu_mdu_iter -- EX-stage ALU with iterative multiply/divide
//
// Purpose:
//   Single-cycle ALU operations (add/sub/logic/compare/shift) plus radix-2
//   iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring). Every result is
//   registered. A valid/ready handshake lets the pipeline stall while an
//   iterative op runs.
//
// Handshake (valid/ready):
//   An op is taken on a rising clk edge when in_valid && in_ready. a/b/op are
//   looked at only in that cycle. A result is offered while out_valid is high
//   and is held stable until a cycle with out_ready high, which retires it.
//   in_ready is high in IDLE, or in DONE when the current result is being
//   retired in the same cycle (back-to-back issue, no bubble).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   op issue handshake
//   op[14:0]            one-hot opcode: ADD SUB AND OR XOR NOR SLT SLTU SLL
//                       SRL SRA (bits 0..10), MULT MULTU DIV DIVU (bits 11..14)
//   a, b                operands; shifts move b by a[SHAMT_W-1:0]
//   out_valid/out_ready result handshake
//   result              ALU result; equals lo for mul/div
//   hi, lo              mul: product {hi,lo}; div: hi=remainder, lo=quotient.
//                       Both are zero for single-cycle ALU ops.
//   overflow, carryout  adder flags (ADD/SUB/SLT/SLTU); 0 otherwise
//   zero                result == 0 (0 for an illegal op, whose outputs are
//                       all zero)
//   cancel              flush input, only when ALU_CANCEL_EN is defined
//   state_o             current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Optional feature (macro ALU_CANCEL_EN):
//   Adds the cancel input. cancel=1 in BUSY or DONE returns to IDLE on the
//   next edge with outputs left unchanged; it wins over accept and completion
//   and forces in_ready low.
// ============================================================================
module alu_mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             carryout,
    output logic             zero,
`ifdef ALU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic cancel_w;
`ifdef ALU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic op_onehot, op_alu, op_md, accept;

    assign op_onehot = (op != '0) && ((op & (op - 15'd1)) == '0);
    assign op_alu    = op_onehot && (|op[10:0]);
    assign op_md     = op_onehot && (|op[14:11]);
    assign accept    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle ALU path
    // ------------------------------------------------------------------
    logic               invert;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum_w;
    logic               cf, add_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_cout, alu_zero;

    assign invert  = op[1] | op[6] | op[7];
    assign addend  = invert ? ~b : b;
    assign sum_w   = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, invert};
    assign cf      = sum_w[WIDTH];
    // Carry into the MSB xor carry out of the MSB.
    assign add_ovf = a[WIDTH-1] ^ addend[WIDTH-1] ^ cf ^ sum_w[WIDTH-1];
    assign shamt   = a[SHAMT_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_cout = 1'b0;
        if (op_alu) begin
            case (1'b1)
                op[0], op[1]: alu_res = sum_w[WIDTH-1:0];
                op[2]:        alu_res = a & b;
                op[3]:        alu_res = a | b;
                op[4]:        alu_res = a ^ b;
                op[5]:        alu_res = ~(a | b);
                op[6]:        alu_res = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ add_ovf};
                op[7]:        alu_res = {{(WIDTH-1){1'b0}}, ~cf};
                op[8]:        alu_res = b << shamt;
                op[9]:        alu_res = b >> shamt;
                op[10]:       alu_res = $signed(b) >>> shamt;
                default:      alu_res = '0;
            endcase
            if (op[0] | op[1] | op[6] | op[7]) begin
                alu_ovf  = add_ovf;
                alu_cout = cf ^ invert;
            end
        end
    end

    // Illegal ops report zero=0 so that every output is zero.
    assign alu_zero = op_alu && (alu_res == '0);

    // ------------------------------------------------------------------
    // Iterative multiply / divide datapath
    // acc_q holds {hi_acc, multiplier} for mul and {remainder, quotient}
    // for div; both start as {0, |a|}, so one load serves both.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;        // |b|: multiplicand or divisor
    logic [WIDTH-1:0]   a_q;           // raw a, returned as hi on divide-by-zero
    logic [SHAMT_W-1:0] cnt_q;
    logic               mul_q, neg_q, rneg_q, dbz_q;

    logic               md_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign md_signed = op[11] | op[13];
    assign a_neg     = md_signed & a[WIDTH-1];
    assign b_neg     = md_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] iter_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    // When the trial subtraction succeeds the remainder fits in WIDTH bits.
    assign div_diff = div_sh[WIDTH-1:0] - opnd_q;
    assign div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    assign iter_next = mul_q ? mul_next : div_next;

    // Sign fix-up and divide-by-zero override applied to the final iteration.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   md_hi, md_lo;

    assign prod_s = neg_q ? -iter_next : iter_next;

    always_comb begin
        md_hi = '0;
        md_lo = '0;
        if (mul_q) begin
            md_hi = prod_s[2*WIDTH-1:WIDTH];
            md_lo = prod_s[WIDTH-1:0];
        end else if (dbz_q) begin
            md_hi = a_q;
            md_lo = '1;
        end else begin
            md_hi = rneg_q ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
            md_lo = neg_q  ? -iter_next[WIDTH-1:0]       : iter_next[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (cancel_w && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = op_md ? S_BUSY : S_DONE;
                S_BUSY: if (cnt_q == '0) state_d = S_DONE;
                S_DONE: begin
                    if (accept)         state_d = op_md ? S_BUSY : S_DONE;
                    else if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready  = !cancel_w && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        out_valid = (state_q == S_DONE);
        state_o   = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             ovf_q, cout_q, zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (!(cancel_w && (state_q != S_IDLE))) begin
            if (accept) begin
                if (op_md) begin
                    acc_q  <= {{WIDTH{1'b0}}, a_mag};
                    opnd_q <= b_mag;
                    a_q    <= a;
                    cnt_q  <= SHAMT_W'(WIDTH - 1);
                    mul_q  <= op[11] | op[12];
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    dbz_q  <= (op[13] | op[14]) && (b == '0);
                end else begin
                    result_q <= alu_res;
                    hi_q     <= '0;
                    lo_q     <= '0;
                    ovf_q    <= alu_ovf;
                    cout_q   <= alu_cout;
                    zero_q   <= alu_zero;
                end
            end else if (state_q == S_BUSY) begin
                acc_q <= iter_next;
                cnt_q <= cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    result_q <= md_lo;
                    hi_q     <= md_hi;
                    lo_q     <= md_lo;
                    ovf_q    <= 1'b0;
                    cout_q   <= 1'b0;
                    zero_q   <= (md_lo == '0);
                end
            end
        end
    end

    assign result   = result_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign overflow = ovf_q;
    assign carryout = cout_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_mdu_iter.sv
// ============================================================================
// tb_alu_mdu_iter -- self-checking bench for alu_mdu_iter (WIDTH=32)
//
// Structure: clock/reset block, driver tasks, a scoreboard fed by an
// expected-value queue built from a behavioural reference model, and a final
// report line. Inputs change 1 time unit after the rising edge; outputs are
// sampled at that point or one unit later.
// ============================================================================
module tb_alu_mdu_iter;

    localparam int W  = 32;
    localparam int EW = 3 * W + 3;   // {result, hi, lo, overflow, carryout, zero}

    localparam logic [14:0] OP_ADD   = 15'h0001;
    localparam logic [14:0] OP_SUB   = 15'h0002;
    localparam logic [14:0] OP_XOR   = 15'h0010;
    localparam logic [14:0] OP_SLTU  = 15'h0080;
    localparam logic [14:0] OP_SRA   = 15'h0400;
    localparam logic [14:0] OP_MULT  = 15'h0800;
    localparam logic [14:0] OP_DIV   = 15'h2000;
    localparam logic [14:0] OP_DIVU  = 15'h4000;

    localparam logic [W-1:0] MIN_V = 32'h8000_0000;
    localparam logic [W-1:0] MAX_V = 32'h7FFF_FFFF;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [14:0]   op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          overflow;
    logic          carryout;
    logic          zero;
    logic [1:0]    state_o;
`ifdef ALU_CANCEL_EN
    logic          cancel;
`endif

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    alu_mdu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .lo        (lo),
        .overflow  (overflow),
        .carryout  (carryout),
        .zero      (zero),
`ifdef ALU_CANCEL_EN
        .cancel    (cancel),
`endif
        .state_o   (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [14:0] o,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [W-1:0]   r, h, l, d;
        logic           v, c;
        logic [W:0]     wide;
        logic [2*W-1:0] p;
        int             k;
        r = '0; h = '0; l = '0; v = 1'b0; c = 1'b0; k = -1;
        if ($countones(o) != 1) return '0;
        for (int i = 0; i < 15; i++) if (o[i]) k = i;
        d = x - y;
        case (k)
            0: begin
                wide = {1'b0, x} + {1'b0, y};
                r = wide[W-1:0];
                c = wide[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            1, 6, 7: begin
                c = (x < y);
                v = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
                if (k == 1)      r = d;
                else if (k == 6) r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
                else             r = {{(W-1){1'b0}}, (x < y)};
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = ~(x | y);
            8: r = y << x[4:0];
            9: r = y >> x[4:0];
            10: r = $signed(y) >>> x[4:0];
            11: begin
                p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                h = p[2*W-1:W]; l = p[W-1:0];
            end
            12: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                h = p[2*W-1:W]; l = p[W-1:0];
            end
            13: begin
                if (y == '0) begin
                    l = '1; h = x;
                end else if (x == MIN_V && y == '1) begin
                    l = MIN_V; h = '0;
                end else begin
                    l = $signed(x) / $signed(y);
                    h = $signed(x) % $signed(y);
                end
            end
            default: begin
                if (y == '0) begin
                    l = '1; h = x;
                end else begin
                    l = x / y; h = x % y;
                end
            end
        endcase
        if (k >= 11) r = l;
        return {r, h, l, v, c, (r == '0)};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MIN_V;
            4: return MAX_V;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check({tag, ".result"},   result,   e[3*W+2:2*W+3]);
        check({tag, ".hi"},       hi,       e[2*W+2:W+3]);
        check({tag, ".lo"},       lo,       e[W+2:3]);
        check({tag, ".overflow"}, overflow, e[2]);
        check({tag, ".carryout"}, carryout, e[1]);
        check({tag, ".zero"},     zero,     e[0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (block must be ready), wait a bounded time for the result
    // and score it. Returns in the first out_valid cycle with out_ready=1.
    task automatic run_op(input string tag, input logic [14:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit probe_busy);
        int lat;
        int lat_exp;
        lat_exp = (($countones(o) == 1) && (|o[14:11])) ? W + 1 : 1;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, in_ready, 1);
        exp_q.push_back(model(o, x, y));
        tick();
        in_valid = 1'b0;
        op = 15'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat <= W + 5) begin
            if (probe_busy && lat == 2) begin
                check({tag, ".busy_in_ready"}, in_ready, 0);
                check({tag, ".busy_state"}, state_o, 1);
            end
            if (probe_busy) in_valid = (lat >= 2 && lat < 5);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, lat, lat_exp);
        check({tag, ".out_valid"}, out_valid, 1);
        compare_out(tag);
    endtask

    // Accept an op and return in the first cycle after acceptance.
    task automatic launch(input logic [14:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        check("launch.in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [EW-1:0] e;
        logic [W-1:0]  x, y;
        logic [14:0]   o;
        int            pick;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
`ifdef ALU_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready",  in_ready, 1);
        check("rst.state",     state_o, 0);
        check("rst.result",    result, 0);
        check("rst.hi",        hi, 0);
        check("rst.lo",        lo, 0);
        check("rst.flags",     {overflow, carryout, zero}, 0);
        tick();

        // ADD signed overflow edge
        run_op("add_ovf", OP_ADD, MAX_V, 32'd1, 1'b0);
        check("add_ovf.const_result", result, 32'h8000_0000);
        check("add_ovf.const_flags", {overflow, carryout, zero}, 3'b100);

        run_op("sub", OP_SUB, 32'd3, 32'd5, 1'b0);
        run_op("sltu", OP_SLTU, 32'd0, 32'd1, 1'b0);
        check("sltu.const_result", result, 32'd1);
        run_op("sra", OP_SRA, 32'd4, 32'h8000_0000, 1'b0);
        check("sra.const_result", result, 32'hF800_0000);

        // MULT -2 * 3 with busy-cycle probing (latency W+1)
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        check("mult.const_hi", hi, 32'hFFFF_FFFF);
        check("mult.const_lo", lo, 32'hFFFF_FFFA);

        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div.const_lo", lo, 32'hFFFF_FFFD);
        check("div.const_hi", hi, 32'hFFFF_FFFF);
        run_op("divu0", OP_DIVU, 32'd5, 32'd0, 1'b0);
        check("divu0.const_lo", lo, 32'hFFFF_FFFF);
        check("divu0.const_hi", hi, 32'd5);
        run_op("divmin", OP_DIV, MIN_V, 32'hFFFF_FFFF, 1'b0);
        check("divmin.const_lo", lo, MIN_V);
        check("divmin.const_hi_ovf", {hi, overflow}, 33'd0);
        run_op("illegal2", 15'h0003, 32'd7, 32'd9, 1'b0);
        tick();

        // Back-to-back ADDs: one result per cycle
        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom;
            op = OP_ADD; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("b2b.in_ready", in_ready, 1);
            exp_q.push_back(model(OP_ADD, x, y));
            tick();
            check("b2b.out_valid", out_valid, 1);
            compare_out("b2b");
        end
        in_valid = 1'b0;
        tick();

        // Consumer stall: outputs hold, in_ready low
        x = $urandom; y = $urandom;
        e = model(OP_XOR, x, y);
        run_op("stall", OP_XOR, x, y, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = $urandom; b = $urandom;
        #1;
        check("stall.in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.out_valid", out_valid, 1);
            check("stall.in_ready", in_ready, 0);
            check("stall.result", result, e[3*W+2:2*W+3]);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("stall.release_valid", out_valid, 0);
        check("stall.release_ready", in_ready, 1);

        // Reset in the middle of a DIV (counter at 10)
        launch(OP_DIV, 32'd1000, 32'd7);
        repeat (21) tick();
        check("rstmid.busy", state_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid.out_valid", out_valid, 0);
        check("rstmid.in_ready", in_ready, 1);
        check("rstmid.result", result, 0);
        check("rstmid.hi_lo", {hi, lo}, 64'd0);
        run_op("rstmid_add", OP_ADD, 32'd2, 32'd3, 1'b0);
        check("rstmid_add.const", result, 32'd5);

`ifdef ALU_CANCEL_EN
        // Cancel in the middle of a MULT: back to IDLE, outputs unchanged
        launch(OP_MULT, 32'd1234, 32'd5678);
        repeat (21) tick();
        cancel = 1'b1; in_valid = 1'b1; op = OP_ADD;
        #1;
        check("cancel.in_ready0", in_ready, 0);
        tick();
        cancel = 1'b0; in_valid = 1'b0;
        check("cancel.out_valid", out_valid, 0);
        check("cancel.state", state_o, 0);
        check("cancel.in_ready", in_ready, 1);
        check("cancel.result_kept", result, 32'd5);
        run_op("cancel_add", OP_ADD, 32'd10, 32'd20, 1'b0);
        check("cancel_add.const", result, 32'd30);
`endif

        // Randomised ops against the reference model
        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 16);
            if (pick < 15)       o = 15'd1 << pick;
            else if (pick == 15) o = '0;
            else                 o = (15'd1 << $urandom_range(0, 7)) | (15'd1 << $urandom_range(8, 14));
            x = pick_operand();
            y = pick_operand();
            run_op("rand", o, x, y, 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu_iter.md
Name: alu_mdu_iter

Overview:
- Parametrised successor to the single-cycle core ALU.
- Adds a valid/ready handshake, a registered result, and iterative multiply/divide producing a 2*WIDTH {hi,lo} result.
- Sits in the EX stage: the pipeline issues one op, then stalls on in_ready/out_valid while an iterative op runs.
- Add/sub/logic/compare/shift semantics and flag meanings are unchanged from the single-cycle ALU.

Parameters:
- WIDTH, 32, datapath width in bits; legal values 8..64, power of two.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from A.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  op/operands valid.
- in_ready  output  1  block can accept an op this cycle.
- op  input  15  one-hot opcode:
  - bits 0..10: ADD SUB AND OR XOR NOR SLT SLTU SLL SRL SRA.
  - bits 11..14: MULT MULTU DIV DIVU.
- a  input  WIDTH  operand A; shift amount is a[SHAMT_W-1:0].
- b  input  WIDTH  operand B; for shifts, the value shifted.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  ALU result; for mul/div, equals lo.
- hi  output  WIDTH  MULT: product high half; DIV: remainder. Zero for ALU ops.
- lo  output  WIDTH  MULT: product low half; DIV: quotient.
- overflow  output  1  signed overflow (ADD/SUB/SLT/SLTU path); 0 for mul/div.
- carryout  output  1  carry for ADD, borrow for SUB/SLT/SLTU; 0 otherwise.
- zero  output  1  result == 0.
- cancel  input  1  present only with ALU_CANCEL_EN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0. result, hi, lo, overflow, carryout, zero all 0.
- Opcode rules:
  - op with zero bits set, or more than one bit set, is illegal.
  - An illegal op is accepted and produces all-zero outputs after 1 cycle (no X).
- Handshake:
  - An op is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Results hold stable while out_valid && !out_ready.
- State machine (IDLE, BUSY, DONE):
  - IDLE, accept ALU op: compute combinationally, register outputs -> DONE. Result visible the cycle after accept (latency 1).
  - IDLE, accept mul/div op: latch operands, counter=WIDTH-1 -> BUSY.
  - BUSY: one iteration per cycle, counter decrements. At counter==0, perform the last iteration, register outputs -> DONE.
    - Accept at cycle T gives out_valid at T+WIDTH+1 (T+33 for WIDTH=32).
  - DONE: out_valid=1.
    - out_ready && in_valid: accept the new op as from IDLE (back-to-back, no bubble).
    - out_ready && !in_valid: -> IDLE.
    - else stay.
- Arithmetic:
  - ADD/SUB: WIDTH+1-bit sum of A and (invert ? ~B : B) + invert; invert set for SUB/SLT/SLTU.
  - overflow = A[W-1]^addend[W-1]^cf^sum[W-1]; carryout = cf^invert.
  - SLT = sum[W-1]^overflow; SLTU = !cf.
  - SLL/SRL/SRA shift b by a[SHAMT_W-1:0]; SRA fills with b[W-1].
- Multiply:
  - Radix-2 shift-add on magnitudes.
  - MULT: signed magnitudes, product negated when sign(a)^sign(b).
- Divide:
  - Radix-2 restoring on magnitudes.
  - DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide boundary cases:
  - Divide by zero: lo = all ones, hi = a; still takes WIDTH cycles.
  - DIV MIN/-1: lo = MIN, hi = 0; overflow stays 0.
- Reset mid-operation (BUSY or DONE): return to reset values next cycle; partial result discarded.
- Inputs a/b/op are ignored except in the accept cycle.

Optional Feature:
- Macro: ALU_CANCEL_EN.
- Defined:
  - cancel port exists.
  - cancel=1 in BUSY or DONE -> IDLE next cycle; out_valid=0, outputs unchanged.
  - cancel has priority over accept and completion in the same cycle. An op presented with in_valid in a cancel cycle is not accepted (in_ready forced 0).
  - Used for exception flush.
- Undefined: no cancel port; an iterative op always runs to completion.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, carryout=0, zero=0.
- SLTU a=0, b=1 -> result=1. SRA a=4, b=0x80000000 -> result=0xF8000000.
- MULT a=0xFFFFFFFE (-2), b=3, accepted at T -> out_valid at T+33; hi=0xFFFFFFFF, lo=0xFFFFFFFA; in_ready=0 during BUSY.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- Back-to-back ADD ops with out_ready=1 -> one result per cycle. out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- reset asserted mid-DIV at counter=10 -> next cycle out_valid=0, in_ready=1; a subsequent ADD 2+3 returns 5. With ALU_CANCEL_EN, cancel mid-MULT gives the same IDLE result.
